interrupt_controller: RTL

//  Collects frame (vblank) and keyboard events and presents them one at a time to the active

---
 rtl/interrupt_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Collects vblank (frame) and keyboard events and presents them one at a
//   time to the active processor through an IRQ / IACK / IEND handshake.
//   Key codes are buffered in a small FIFO; lost events are counted.
//
// Ports
//   CLK          system clock
//   RESET        synchronous, active-low reset
//   FRAME_TICK   1-cycle pulse at start of vblank
//   KBD_VALID    1-cycle pulse, KBD_CODE holds a new key
//   KBD_CODE     key code from the keyboard decoder
//   INT_IRQ      00 = frame, 01 = key, 11 = none (10 never driven)
//   INT_IACK     processor acknowledges the posted IRQ
//   INT_IEND     processor finished servicing
//   KBD_KEY      key code for the posted / serviced key IRQ
//   FRAME_DROPS  frames lost, saturating
//   KEY_DROPS    keys lost to a full FIFO, saturating
//   PROTO_ERR    sticky handshake-violation flag
//
// State  | meaning
// IDLE   | nothing posted; pick frame first, then key FIFO head
// POST   | IRQ presented, waiting for IACK
// SERV   | acknowledged, waiting for IEND
// GAP    | one cycle of IRQ=11 so consecutive IRQs are visibly separated

module interrupt_controller #(
    parameter int KEY_DEPTH = 4,
    parameter int CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FRAME_TICK,
    input  logic             KBD_VALID,
    input  logic [7:0]       KBD_CODE,
    output logic [1:0]       INT_IRQ,
    input  logic             INT_IACK,
    input  logic             INT_IEND,
    output logic [7:0]       KBD_KEY,
    output logic [CNT_W-1:0] FRAME_DROPS,
    output logic [CNT_W-1:0] KEY_DROPS,
    output logic             PROTO_ERR
);

    localparam int PTR_W = $clog2(KEY_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POST = 2'd1;
    localparam logic [1:0] S_SERV = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [1:0] IRQ_FRAME = 2'b00;
    localparam logic [1:0] IRQ_KEY   = 2'b01;
    localparam logic [1:0] IRQ_NONE  = 2'b11;

    logic [1:0]        state;
    logic              src_key;
    logic              frame_pend;

    logic [7:0]        key_mem [KEY_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;

    logic in_post;
    logic ack;
    logic frame_clr;
    logic pop;
    logic full;
    logic push_ok;
    logic key_drop;
    logic frame_drop;
    logic proto_viol;

    always_comb begin
        in_post    = (state == S_POST);
        ack        = in_post && INT_IACK;
        frame_clr  = ack && !src_key;
        pop        = ack && src_key;
        full       = (fifo_cnt == FCNT_W'(KEY_DEPTH));
        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        push_ok    = KBD_VALID && (!full || pop);
        key_drop   = KBD_VALID && full && !pop;
        frame_drop = FRAME_TICK && frame_pend && !frame_clr;
        // IACK+IEND together in POST is caught by the IEND-outside-SERV term.
        proto_viol = (INT_IACK && !in_post) || (INT_IEND && (state != S_SERV));
    end

    // Storage needs no reset: contents are only read when fifo_cnt says valid.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            key_mem[wr_ptr] <= KBD_CODE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state       <= S_IDLE;
            src_key     <= 1'b0;
            frame_pend  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            INT_IRQ     <= IRQ_NONE;
            KBD_KEY     <= 8'h00;
            FRAME_DROPS <= '0;
            KEY_DROPS   <= '0;
            PROTO_ERR   <= 1'b0;
        end else begin
            // Set has priority over clear.
            if (FRAME_TICK) begin
                frame_pend <= 1'b1;
            end else if (frame_clr) begin
                frame_pend <= 1'b0;
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (frame_drop && (FRAME_DROPS != '1)) begin
                FRAME_DROPS <= FRAME_DROPS + 1'b1;
            end
            if (key_drop && (KEY_DROPS != '1)) begin
                KEY_DROPS <= KEY_DROPS + 1'b1;
            end
            if (proto_viol) begin
                PROTO_ERR <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (frame_pend) begin
                        state   <= S_POST;
                        src_key <= 1'b0;
                        INT_IRQ <= IRQ_FRAME;
                    end else if (fifo_cnt != '0) begin
                        state   <= S_POST;
                        src_key <= 1'b1;
                        INT_IRQ <= IRQ_KEY;
                        KBD_KEY <= key_mem[rd_ptr];
                    end
                end
                S_POST: begin
                    if (INT_IACK) begin
                        state <= S_SERV;
                    end
                end
                S_SERV: begin
                    if (INT_IEND) begin
                        state   <= S_GAP;
                        INT_IRQ <= IRQ_NONE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    INT_IRQ <= IRQ_NONE;
                end
            endcase
        end
    end

endmodule
